// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the RV32I multi-cycle sequencer (master) and the datapath (slave).
// ILLEGAL_OP_TRAP_EN adds the illegal_op status line.
interface multicycle_control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_is_fetch;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic [1:0] alu_src_a;
  logic       alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] wb_sel;
  logic       reg_write;
  logic       instr_retired;
  logic       mem_timeout;
  logic [2:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal_op;
`endif

  modport master (
    input  opcode, funct3, branch_taken, mem_ready,
    output mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, wb_sel, reg_write, instr_retired,
           mem_timeout, state
`ifdef ILLEGAL_OP_TRAP_EN
           , illegal_op
`endif
  );

  modport slave (
    output opcode, funct3, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, wb_sel, reg_write, instr_retired,
           mem_timeout, state
`ifdef ILLEGAL_OP_TRAP_EN
           , illegal_op
`endif
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with memory-wait timeout.
// Define ILLEGAL_OP_TRAP_EN to halt on unknown opcodes instead of retiring them as NOPs.
module multicycle_control_unit #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_control_unit_if.master     bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd7
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal_op_q, illegal_op_d;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      op_q          <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_op_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_op_q  <= illegal_op_d;
`endif
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d            = state_q;
    op_d               = op_q;
    wait_cnt_d         = '0;
    mem_timeout_d      = mem_timeout_q;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_op_d       = illegal_op_q;
`endif
    bus.mem_req        = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_is_fetch   = 1'b0;
    bus.ir_write       = 1'b0;
    bus.pc_write       = 1'b0;
    bus.pc_src         = 2'd0;
    bus.alu_src_a      = 2'd0;
    bus.alu_src_b      = 1'b0;
    bus.alu_op         = 2'd0;
    bus.wb_sel         = 2'd0;
    bus.reg_write      = 1'b0;
    bus.instr_retired  = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.mem_req      = 1'b1;
        bus.mem_is_fetch = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          state_d      = S_DECODE;
        end
      end

      S_DECODE: begin
        op_d    = bus.opcode;
        state_d = S_EXECUTE;
      end

      S_EXECUTE: begin
        state_d = S_WRITEBACK;
        case (op_q)
          OP_R: begin
            bus.alu_op = 2'd1;
          end
          OP_I: begin
            bus.alu_src_b = 1'b1;
            bus.alu_op    = 2'd1;
          end
          OP_LOAD, OP_STORE: begin
            bus.alu_src_b = 1'b1;
            state_d       = S_MEM;
          end
          OP_LUI: begin
            bus.alu_src_a = 2'd2;
            bus.alu_src_b = 1'b1;
          end
          OP_AUIPC: begin
            bus.alu_src_a = 2'd1;
            bus.alu_src_b = 1'b1;
          end
          OP_JAL: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'd1;
          end
          OP_JALR: begin
            // ALU forms rs1+imm as the jump target
            bus.alu_src_b = 1'b1;
            bus.pc_write  = 1'b1;
            bus.pc_src    = 2'd2;
          end
          OP_BRANCH: begin
            bus.alu_op        = 2'd2;
            bus.pc_write      = 1'b1;
            bus.pc_src        = bus.branch_taken ? 2'd1 : 2'd0;
            bus.instr_retired = 1'b1;
            state_d           = S_FETCH;
          end
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_op_d = 1'b1;
            state_d      = S_HALT;
`else
            state_d      = S_WRITEBACK;
`endif
          end
        endcase
      end

      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (op_q == OP_STORE);
        if (bus.mem_ready) begin
          if (op_q == OP_STORE) begin
            bus.pc_write      = 1'b1;
            bus.instr_retired = 1'b1;
            state_d           = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end

      S_WRITEBACK: begin
        bus.instr_retired = 1'b1;
        state_d           = S_FETCH;
        case (op_q)
          OP_LOAD: begin
            bus.reg_write = 1'b1;
            bus.wb_sel    = 2'd1;
            bus.pc_write  = 1'b1;
          end
          OP_JAL, OP_JALR: begin
            bus.reg_write = 1'b1;
            bus.wb_sel    = 2'd2;
          end
          OP_R, OP_I, OP_LUI, OP_AUIPC: begin
            bus.reg_write = 1'b1;
            bus.pc_write  = 1'b1;
          end
          default: begin
            bus.pc_write = 1'b1;
          end
        endcase
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Unanswered memory request: count, and halt once the budget is spent.
    if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready) begin
      if (wait_cnt_q == WAIT_LAST) begin
        state_d       = S_HALT;
        mem_timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end

    // An edge with rst_n low aborts the instruction, so no write may land on it.
    if (!rst_n) begin
      bus.mem_req       = 1'b0;
      bus.mem_we        = 1'b0;
      bus.ir_write      = 1'b0;
      bus.pc_write      = 1'b0;
      bus.reg_write     = 1'b0;
      bus.instr_retired = 1'b0;
    end
  end

  assign bus.state       = state_q;
  assign bus.mem_timeout = mem_timeout_q;
`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.illegal_op  = illegal_op_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit, built with MEM_WAIT_MAX=4.
// Honours ILLEGAL_OP_TRAP_EN for the unknown-opcode step.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(.MEM_WAIT_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Land 2 time units after the next rising edge; inputs are set there, checks follow a #1.
  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst_n            = 1'b0;
    bus.opcode       = 7'd0;
    bus.funct3       = 3'd0;
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #3;
    check("rst_state",     8'(bus.state), 8'd0);
    check("rst_timeout",   8'(bus.mem_timeout), 8'd0);
    check("rst_mem_req",   8'(bus.mem_req), 8'd0);
`ifdef ILLEGAL_OP_TRAP_EN
    check("rst_illegal",   8'(bus.illegal_op), 8'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rst_fetch_req", 8'(bus.mem_req), 8'd1);
    check("rst_fetch_src", 8'(bus.mem_is_fetch), 8'd1);
    check("rst_ir_write",  8'(bus.ir_write), 8'd0);

    // ADDI x1, x0, 5 : 0x00500093
    bus.opcode = OP_I; bus.funct3 = 3'd0; bus.mem_ready = 1'b1;
    #1;
    check("addi_c1_state", 8'(bus.state), 8'd0);
    check("addi_c1_irw",   8'(bus.ir_write), 8'd1);
    check("addi_c1_we",    8'(bus.mem_we), 8'd0);
    adv(); bus.mem_ready = 1'b0; #1;
    check("addi_c2_state", 8'(bus.state), 8'd1);
    check("addi_c2_req",   8'(bus.mem_req), 8'd0);
    adv(); #1;
    check("addi_c3_state", 8'(bus.state), 8'd2);
    check("addi_c3_srcb",  8'(bus.alu_src_b), 8'd1);
    check("addi_c3_aluop", 8'(bus.alu_op), 8'd1);
    check("addi_c3_regw",  8'(bus.reg_write), 8'd0);
    adv(); #1;
    check("addi_c4_state", 8'(bus.state), 8'd4);
    check("addi_c4_regw",  8'(bus.reg_write), 8'd1);
    check("addi_c4_ret",   8'(bus.instr_retired), 8'd1);
    check("addi_c4_wbsel", 8'(bus.wb_sel), 8'd0);
    check("addi_c4_pcw",   8'(bus.pc_write), 8'd1);
    check("addi_c4_pcsrc", 8'(bus.pc_src), 8'd0);
    adv(); #1;
    check("addi_c5_state", 8'(bus.state), 8'd0);
    check("addi_c5_regw",  8'(bus.reg_write), 8'd0);

    // LW with memory silent 3 cycles in MEM; ready arrives on the last allowed cycle
    bus.opcode = OP_LOAD; bus.funct3 = 3'd2; bus.mem_ready = 1'b1;
    #1;
    check("lw_c1_irw",     8'(bus.ir_write), 8'd1);
    adv(); bus.mem_ready = 1'b0; #1;
    check("lw_c2_state",   8'(bus.state), 8'd1);
    adv(); #1;
    check("lw_c3_aluop",   8'(bus.alu_op), 8'd0);
    check("lw_c3_srcb",    8'(bus.alu_src_b), 8'd1);
    for (int i = 0; i < 3; i++) begin
      adv(); #1;
      check("lw_mem_state", 8'(bus.state), 8'd3);
      check("lw_mem_req",   8'(bus.mem_req), 8'd1);
      check("lw_mem_we",    8'(bus.mem_we), 8'd0);
      check("lw_mem_fetch", 8'(bus.mem_is_fetch), 8'd0);
    end
    adv(); bus.mem_ready = 1'b1; #1;
    check("lw_c7_state",   8'(bus.state), 8'd3);
    check("lw_c7_req",     8'(bus.mem_req), 8'd1);
    check("lw_c7_ret",     8'(bus.instr_retired), 8'd0);
    adv(); bus.mem_ready = 1'b0; #1;
    check("lw_c8_state",   8'(bus.state), 8'd4);
    check("lw_c8_wbsel",   8'(bus.wb_sel), 8'd1);
    check("lw_c8_regw",    8'(bus.reg_write), 8'd1);
    check("lw_c8_ret",     8'(bus.instr_retired), 8'd1);
    adv(); #1;
    check("lw_c9_state",   8'(bus.state), 8'd0);

    // BEQ taken, then BEQ not taken
    for (int t = 1; t >= 0; t--) begin
      bus.opcode = OP_BRANCH; bus.funct3 = 3'd0; bus.mem_ready = 1'b1;
      #1;
      check("beq_fetch_irw", 8'(bus.ir_write), 8'd1);
      adv(); bus.mem_ready = 1'b0; #1;
      check("beq_dec_regw",  8'(bus.reg_write), 8'd0);
      adv(); bus.branch_taken = 1'(t); #1;
      check("beq_ex_state",  8'(bus.state), 8'd2);
      check("beq_ex_aluop",  8'(bus.alu_op), 8'd2);
      check("beq_ex_pcw",    8'(bus.pc_write), 8'd1);
      check("beq_ex_pcsrc",  8'(bus.pc_src), 8'(t));
      check("beq_ex_ret",    8'(bus.instr_retired), 8'd1);
      check("beq_ex_regw",   8'(bus.reg_write), 8'd0);
      adv(); bus.branch_taken = 1'b0; #1;
      check("beq_next_state", 8'(bus.state), 8'd0);
    end

    // JAL
    bus.opcode = OP_JAL; bus.mem_ready = 1'b1;
    #1;
    adv(); bus.mem_ready = 1'b0; #1;
    adv(); #1;
    check("jal_ex_pcw",    8'(bus.pc_write), 8'd1);
    check("jal_ex_pcsrc",  8'(bus.pc_src), 8'd1);
    adv(); #1;
    check("jal_wb_state",  8'(bus.state), 8'd4);
    check("jal_wb_wbsel",  8'(bus.wb_sel), 8'd2);
    check("jal_wb_regw",   8'(bus.reg_write), 8'd1);
    check("jal_wb_pcw",    8'(bus.pc_write), 8'd0);
    adv(); #1;

    // SW
    bus.opcode = OP_STORE; bus.funct3 = 3'd2; bus.mem_ready = 1'b1;
    #1;
    adv(); bus.mem_ready = 1'b0; #1;
    adv(); #1;
    check("sw_ex_srcb",    8'(bus.alu_src_b), 8'd1);
    check("sw_ex_regw",    8'(bus.reg_write), 8'd0);
    adv(); bus.mem_ready = 1'b1; #1;
    check("sw_mem_state",  8'(bus.state), 8'd3);
    check("sw_mem_we",     8'(bus.mem_we), 8'd1);
    check("sw_mem_pcw",    8'(bus.pc_write), 8'd1);
    check("sw_mem_pcsrc",  8'(bus.pc_src), 8'd0);
    check("sw_mem_ret",    8'(bus.instr_retired), 8'd1);
    check("sw_mem_regw",   8'(bus.reg_write), 8'd0);
    adv(); #1;
    check("sw_next_state", 8'(bus.state), 8'd0);

    // JALR and LUI: EXECUTE selects only
    bus.opcode = OP_JALR; bus.mem_ready = 1'b1;
    #1;
    adv(); bus.mem_ready = 1'b0; #1;
    adv(); #1;
    check("jalr_ex_pcsrc", 8'(bus.pc_src), 8'd2);
    adv(); #1;
    check("jalr_wb_wbsel", 8'(bus.wb_sel), 8'd2);
    adv(); bus.opcode = OP_LUI; bus.mem_ready = 1'b1; #1;
    adv(); bus.mem_ready = 1'b0; #1;
    adv(); #1;
    check("lui_ex_srca",   8'(bus.alu_src_a), 8'd2);
    adv(); #1;
    check("lui_wb_regw",   8'(bus.reg_write), 8'd1);
    adv(); #1;

    // Unknown opcode 0x7F
    bus.opcode = 7'h7F; bus.mem_ready = 1'b1;
    #1;
    adv(); bus.mem_ready = 1'b0; #1;
    adv(); #1;
    check("ill_ex_pcw",    8'(bus.pc_write), 8'd0);
`ifdef ILLEGAL_OP_TRAP_EN
    check("ill_ex_ret",    8'(bus.instr_retired), 8'd0);
    adv(); #1;
    check("ill_state",     8'(bus.state), 8'd7);
    check("ill_flag",      8'(bus.illegal_op), 8'd1);
    check("ill_timeout",   8'(bus.mem_timeout), 8'd0);
    check("ill_halt_req",  8'(bus.mem_req), 8'd0);
    rst_n = 1'b0;
    adv(); rst_n = 1'b1; #1;
    check("ill_rst_state", 8'(bus.state), 8'd0);
    check("ill_rst_flag",  8'(bus.illegal_op), 8'd0);
`else
    adv(); #1;
    check("nop_wb_state",  8'(bus.state), 8'd4);
    check("nop_wb_regw",   8'(bus.reg_write), 8'd0);
    check("nop_wb_ret",    8'(bus.instr_retired), 8'd1);
    check("nop_wb_pcw",    8'(bus.pc_write), 8'd1);
    check("nop_wb_pcsrc",  8'(bus.pc_src), 8'd0);
    adv(); #1;
    check("nop_next_state", 8'(bus.state), 8'd0);
`endif

    // Fetch timeout with MEM_WAIT_MAX=4
    bus.opcode = OP_I; bus.mem_ready = 1'b0;
    #1;
    check("to_c1_state",   8'(bus.state), 8'd0);
    for (int i = 0; i < 3; i++) begin
      adv(); #1;
      check("to_wait_state", 8'(bus.state), 8'd0);
      check("to_wait_flag",  8'(bus.mem_timeout), 8'd0);
    end
    adv(); #1;
    check("to_halt_state", 8'(bus.state), 8'd7);
    check("to_halt_flag",  8'(bus.mem_timeout), 8'd1);
    check("to_halt_req",   8'(bus.mem_req), 8'd0);
    bus.mem_ready = 1'b1;
    #1;
    check("to_halt_irw",   8'(bus.ir_write), 8'd0);
    adv(); #1;
    check("to_absorb",     8'(bus.state), 8'd7);
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    adv(); rst_n = 1'b1; #1;
    check("to_rst_state",  8'(bus.state), 8'd0);
    check("to_rst_flag",   8'(bus.mem_timeout), 8'd0);
    check("to_rst_req",    8'(bus.mem_req), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
